// File: rtl/fwd_ctrl_unit.sv
// Operand-forwarding and load-use hazard controller for the EX-stage operand muxes.
// Optional FWD_STATS_EN adds saturating stall and forward event counters.
module fwd_ctrl_unit #(
  parameter int REG_ADDR_W   = 4,
  parameter int ZERO_REG_FWD = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src_a,
  input  logic [REG_ADDR_W-1:0] id_src_b,
  input  logic                  id_use_a,
  input  logic                  id_use_b,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_wr_en,
  input  logic                  id_is_load,
  input  logic                  flush,
  output logic                  stall,
  output logic                  ex_valid,
  output logic [1:0]            sel_a,
  output logic [1:0]            sel_b
`ifdef FWD_STATS_EN
  ,
  output logic [15:0]           stall_cnt,
  output logic [15:0]           fwd_cnt
`endif
);

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;
  localparam logic [1:0] SEL_IDLE  = 2'b11;

  logic [REG_ADDR_W-1:0] ex_dst;
  logic                  ex_wr;
  logic                  ex_load;
  logic                  mem_valid;
  logic [REG_ADDR_W-1:0] mem_dst;
  logic                  mem_wr;

  logic a_hit_ex, a_hit_mem, b_hit_ex, b_hit_mem;
  logic load_ex;
  logic [1:0] next_sel_a, next_sel_b;

  // Register 0 is a constant unless forwarding of it is explicitly enabled.
  function automatic logic src_match(input logic                  v,
                                     input logic                  w,
                                     input logic [REG_ADDR_W-1:0] dst,
                                     input logic [REG_ADDR_W-1:0] src);
    return v & w & (dst == src) & ((src != '0) | (ZERO_REG_FWD != 0));
  endfunction

  // The newest producer (EX) wins over the older one (MEM).
  function automatic logic [1:0] pick_sel(input logic use_op,
                                          input logic hit_ex,
                                          input logic hit_mem);
    if (!use_op)      return SEL_RF;
    else if (hit_ex)  return SEL_EXMEM;
    else if (hit_mem) return SEL_MEMWB;
    else              return SEL_RF;
  endfunction

  always_comb begin
    a_hit_ex   = src_match(ex_valid, ex_wr, ex_dst, id_src_a);
    a_hit_mem  = src_match(mem_valid, mem_wr, mem_dst, id_src_a);
    b_hit_ex   = src_match(ex_valid, ex_wr, ex_dst, id_src_b);
    b_hit_mem  = src_match(mem_valid, mem_wr, mem_dst, id_src_b);
    stall      = id_valid & ~flush & ex_load &
                 ((a_hit_ex & id_use_a) | (b_hit_ex & id_use_b));
    load_ex    = id_valid & ~flush & ~stall;
    next_sel_a = pick_sel(id_use_a, a_hit_ex, a_hit_mem);
    next_sel_b = pick_sel(id_use_b, b_hit_ex, b_hit_mem);
  end

  // MEM always advances; EX takes the ID instruction or becomes a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_dst    <= '0;
      ex_wr     <= 1'b0;
      ex_load   <= 1'b0;
      mem_valid <= 1'b0;
      mem_dst   <= '0;
      mem_wr    <= 1'b0;
      sel_a     <= SEL_IDLE;
      sel_b     <= SEL_IDLE;
    end else begin
      mem_valid <= ex_valid;
      mem_dst   <= ex_dst;
      mem_wr    <= ex_wr;
      if (load_ex) begin
        ex_valid <= 1'b1;
        ex_dst   <= id_dst;
        ex_wr    <= id_wr_en;
        ex_load  <= id_is_load;
        sel_a    <= next_sel_a;
        sel_b    <= next_sel_b;
      end else begin
        ex_valid <= 1'b0;
        ex_wr    <= 1'b0;
        ex_load  <= 1'b0;
        sel_a    <= SEL_IDLE;
        sel_b    <= SEL_IDLE;
      end
    end
  end

`ifdef FWD_STATS_EN
  logic fwd_hit;

  assign fwd_hit = load_ex & ((next_sel_a != SEL_RF) | (next_sel_b != SEL_RF));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (fwd_hit && fwd_cnt != 16'hFFFF) fwd_cnt <= fwd_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// Directed, table-driven bench for fwd_ctrl_unit (default build, r0 not forwarded).
// Counter checks are compiled in only when FWD_STATS_EN is defined.
module tb_fwd_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_src_a, id_src_b, id_dst;
  logic       id_use_a, id_use_b, id_wr_en, id_is_load, flush;
  logic       stall, ex_valid;
  logic [1:0] sel_a, sel_b;
`ifdef FWD_STATS_EN
  logic [15:0] stall_cnt, fwd_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic       v;
    logic [3:0] a;
    logic [3:0] b;
    logic       ua;
    logic       ub;
    logic [3:0] d;
    logic       wr;
    logic       ld;
    logic       fl;
    logic       e_stall;
    logic [1:0] e_sa;
    logic [1:0] e_sb;
    logic       e_ev;
  } vec_t;

  vec_t vecs[$];

  fwd_ctrl_unit #(.REG_ADDR_W(4), .ZERO_REG_FWD(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_src_a   (id_src_a),
    .id_src_b   (id_src_b),
    .id_use_a   (id_use_a),
    .id_use_b   (id_use_b),
    .id_dst     (id_dst),
    .id_wr_en   (id_wr_en),
    .id_is_load (id_is_load),
    .flush      (flush),
    .stall      (stall),
    .ex_valid   (ex_valid),
    .sel_a      (sel_a),
    .sel_b      (sel_b)
`ifdef FWD_STATS_EN
    ,
    .stall_cnt  (stall_cnt),
    .fwd_cnt    (fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t mkv(input int v, input int a, input int b, input int ua,
                               input int ub, input int d, input int wr, input int ld,
                               input int fl, input int es, input int esa, input int esb,
                               input int eev);
    vec_t r;
    r.v = v[0];   r.a = a[3:0];  r.b = b[3:0];   r.ua = ua[0];  r.ub = ub[0];
    r.d = d[3:0]; r.wr = wr[0];  r.ld = ld[0];   r.fl = fl[0];
    r.e_stall = es[0]; r.e_sa = esa[1:0]; r.e_sb = esb[1:0]; r.e_ev = eev[0];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic driveId(input vec_t t);
    id_valid = t.v;  id_src_a = t.a;  id_src_b = t.b;  id_use_a = t.ua;  id_use_b = t.ub;
    id_dst = t.d;    id_wr_en = t.wr; id_is_load = t.ld; flush = t.fl;
  endtask

  // Entered 1 time unit after a rising edge; leaves at the same phase one cycle later.
  task automatic applyStimulus(input vec_t t, input string tag);
    driveId(t);
    #3;
    checkOutput({tag, " stall"}, {15'd0, stall}, {15'd0, t.e_stall});
    @(posedge clk);
    #1;
    checkOutput({tag, " sel_a"}, {14'd0, sel_a}, {14'd0, t.e_sa});
    checkOutput({tag, " sel_b"}, {14'd0, sel_b}, {14'd0, t.e_sb});
    checkOutput({tag, " ex_valid"}, {15'd0, ex_valid}, {15'd0, t.e_ev});
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    //            v  a  b ua ub  d wr ld fl  st sa sb ev
    vecs.push_back(mkv(1, 2, 3, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1)); // ADD r1<-r2,r3
    vecs.push_back(mkv(1, 1, 5, 1, 1, 4, 1, 0, 0, 0, 1, 0, 1)); // SUB r4<-r1,r5
    vecs.push_back(mkv(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 2, 1)); // OR r6<-r5,r1
    vecs.push_back(mkv(1, 2, 3, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1)); // ADD r1
    vecs.push_back(mkv(1, 1, 2, 1, 1, 1, 1, 0, 0, 0, 1, 0, 1)); // ADD r1<-r1,r2
    vecs.push_back(mkv(1, 1, 1, 1, 1, 8, 1, 0, 0, 0, 1, 1, 1)); // newest r1 wins
    vecs.push_back(mkv(1, 8, 1, 1, 0, 2, 1, 1, 0, 0, 1, 0, 1)); // LD r2<-r8
    vecs.push_back(mkv(1, 2, 2, 1, 1, 3, 1, 0, 0, 1, 3, 3, 0)); // load-use stall
    vecs.push_back(mkv(1, 2, 2, 1, 1, 3, 1, 0, 0, 0, 2, 2, 1)); // re-presented
    vecs.push_back(mkv(1, 3, 0, 1, 0, 5, 1, 1, 0, 0, 1, 0, 1)); // LD r5<-r3
    vecs.push_back(mkv(1, 5, 4, 1, 1, 6, 1, 0, 1, 0, 3, 3, 0)); // flush beats stall
    vecs.push_back(mkv(1, 5, 3, 1, 1, 7, 1, 0, 0, 0, 2, 0, 1)); // load now in MEM
    vecs.push_back(mkv(1, 7, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 1)); // write r0
    vecs.push_back(mkv(1, 0, 0, 1, 1, 9, 1, 0, 0, 0, 0, 0, 1)); // read r0 in EX
    vecs.push_back(mkv(1, 0, 9, 1, 1,10, 1, 0, 0, 0, 0, 1, 1)); // r0 in MEM, r9 in EX
    vecs.push_back(mkv(0,10, 0, 1, 0, 0, 0, 0, 0, 0, 3, 3, 0)); // no instruction
    vecs.push_back(mkv(1,10, 0, 1, 0,11, 1, 1, 0, 0, 2, 0, 1)); // LD r11<-r10
    vecs.push_back(mkv(1,11, 4, 0, 1,12, 1, 0, 0, 0, 0, 0, 1)); // unused operand hits load
    vecs.push_back(mkv(1, 1, 0, 1, 0,13, 1, 1, 0, 0, 0, 0, 1)); // LD r13<-r1
    vecs.push_back(mkv(0,13, 0, 1, 0, 0, 0, 0, 0, 0, 3, 3, 0)); // invalid ID, no stall
    vecs.push_back(mkv(1,13,12, 1, 1, 1, 1, 0, 0, 0, 2, 0, 1)); // r13 in MEM, r12 gone

    driveId(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset sel_a", {14'd0, sel_a}, 16'h3);
    checkOutput("reset sel_b", {14'd0, sel_b}, 16'h3);
    checkOutput("reset ex_valid", {15'd0, ex_valid}, 16'h0);
    checkOutput("reset stall", {15'd0, stall}, 16'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Mid-cycle reset while a load-use hazard is pending.
    applyStimulus(mkv(1, 0, 0, 1, 0,14, 1, 1, 0, 0, 0, 0, 1), "ld r14");
    driveId(mkv(1,14,14, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0));
    #2;
    checkOutput("pre-reset stall", {15'd0, stall}, 16'h1);
    rst = 1'b1;
    #1;
    checkOutput("midreset stall", {15'd0, stall}, 16'h0);
    checkOutput("midreset sel_a", {14'd0, sel_a}, 16'h3);
    checkOutput("midreset sel_b", {14'd0, sel_b}, 16'h3);
    checkOutput("midreset ex_valid", {15'd0, ex_valid}, 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(mkv(1,14, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1), "post-reset add");

`ifdef FWD_STATS_EN
    doReset();
    checkOutput("stall_cnt reset", stall_cnt, 16'h0);
    checkOutput("fwd_cnt reset", fwd_cnt, 16'h0);
    applyStimulus(mkv(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0, 1), "stats ld");
    applyStimulus(mkv(1, 2, 2, 1, 1, 3, 1, 0, 0, 1, 3, 3, 0), "stats stall");
    applyStimulus(mkv(1, 2, 2, 1, 1, 3, 1, 0, 0, 0, 2, 2, 1), "stats memfwd");
    applyStimulus(mkv(1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 1, 0, 1), "stats exfwd");
    applyStimulus(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3, 0), "stats idle");
    checkOutput("stall_cnt", stall_cnt, 16'd1);
    checkOutput("fwd_cnt", fwd_cnt, 16'd2);
`else
    doReset();
    applyStimulus(mkv(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0, 1), "final ld");
    applyStimulus(mkv(1, 2, 2, 1, 1, 3, 1, 0, 0, 1, 3, 3, 0), "final stall");
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
